// File: rtl/cw305_trace_match_top.sv
// ---------------------------------------------------------------------------
// cw305_trace_match_top
//
// Trace-pattern trigger block for the CW305 DesignStart target.
//
// A byte-wide host bus (nCS/nRD/nWE strobes, address = {register, subbyte})
// programs up to pNUM_RULES 64-bit pattern/mask rules plus a few control
// registers. A byte-wide trace stream is shifted into a 64-bit history
// register; every enabled rule compares the history against its pattern
// under its mask. Any hit raises trig_out (pulse or toggle mode, gated by a
// global enable) and sets the rule's sticky match flag.
//
// Ports:
//   clk          single clock for host bus and trace logic
//   reset        asynchronous, active-high reset
//   usb_addr     host address {register, subbyte}
//   usb_din      host write data
//   usb_dout     registered host read data (holds after the read)
//   usb_dout_en  high while usb_dout is valid (board tristate enable)
//   usb_nrd      read strobe, active low
//   usb_nwe      write strobe, active low
//   usb_ncs      chip select, active low
//   trace_data   trace byte
//   trace_valid  trace_data valid this cycle
//   trig_out     trigger output
//   match_flags  sticky per-rule match flags
//
// Register map (register index / subbyte):
//   0x00 / 0  PATTERN_ENABLE    bit n enables rule n
//   0x01 / 0  TRIG_TOGGLE       bit 0: 0 = pulse, 1 = toggle
//   0x02 / 0  TRACE_TRIG_ENABLE bit 0 gates trig_out
//   0x03 / 0  MATCH_STATUS      read flags, write clears all flags
//   0x10+n / 0..7  TRACE_PATTERNn, subbyte 0 = MSB
//   0x20+n / 0..7  TRACE_MASKn,    subbyte 0 = MSB
//   Everything else reads 0 and ignores writes.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// cw305_trace_match_rule
//
// One match rule: byte-writable 64-bit pattern and mask registers plus the
// masked compare against the shared history register.
//
// Ports:
//   clk, reset  clock / async active-high reset
//   pat_we      write wr_data into pattern byte byte_idx
//   mask_we     write wr_data into mask byte byte_idx
//   byte_idx    byte lane within the 64-bit value, 0 = bits [7:0]
//   wr_data     host write byte
//   enable      rule enable from PATTERN_ENABLE
//   hist_new    history register was updated on the last edge
//   hist        64-bit trace history, newest byte in [7:0]
//   pattern     current pattern (for readback)
//   mask        current mask (for readback)
//   hit         rule matches the newest history this cycle
// ---------------------------------------------------------------------------
module cw305_trace_match_rule (
    input  logic        clk,
    input  logic        reset,
    input  logic        pat_we,
    input  logic        mask_we,
    input  logic [2:0]  byte_idx,
    input  logic [7:0]  wr_data,
    input  logic        enable,
    input  logic        hist_new,
    input  logic [63:0] hist,
    output logic [63:0] pattern,
    output logic [63:0] mask,
    output logic        hit
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern <= '0;
            mask    <= '0;
        end else begin
            if (pat_we)
                pattern[{byte_idx, 3'b000} +: 8] <= wr_data;
            if (mask_we)
                mask[{byte_idx, 3'b000} +: 8] <= wr_data;
        end
    end

    // Only bits selected by the mask take part; an all-zero mask therefore
    // hits on every new byte while the rule is enabled.
    assign hit = hist_new & enable & (((hist ^ pattern) & mask) == 64'd0);

endmodule

module cw305_trace_match_top #(
    parameter int pADDR_WIDTH   = 21,
    parameter int pBYTECNT_SIZE = 7,
    parameter int pNUM_RULES    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [pADDR_WIDTH-1:0] usb_addr,
    input  logic [7:0]             usb_din,
    output logic [7:0]             usb_dout,
    output logic                   usb_dout_en,
    input  logic                   usb_nrd,
    input  logic                   usb_nwe,
    input  logic                   usb_ncs,
    input  logic [7:0]             trace_data,
    input  logic                   trace_valid,
    output logic                   trig_out,
    output logic [pNUM_RULES-1:0]  match_flags
);

    localparam int REG_W = pADDR_WIDTH - pBYTECNT_SIZE;

    localparam logic [REG_W-1:0] REG_ENABLE = REG_W'(8'h00);
    localparam logic [REG_W-1:0] REG_TOGGLE = REG_W'(8'h01);
    localparam logic [REG_W-1:0] REG_TRIGEN = REG_W'(8'h02);
    localparam logic [REG_W-1:0] REG_STATUS = REG_W'(8'h03);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [REG_W-1:0]         reg_idx;
    logic [pBYTECNT_SIZE-1:0] sub;
    logic                     sub_byte0;
    logic                     sub_in64;
    logic [2:0]               byte_idx;
    logic                     host_wr;
    logic                     host_rd;

    assign reg_idx   = usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
    assign sub       = usb_addr[pBYTECNT_SIZE-1:0];
    assign sub_byte0 = (sub == '0);
    assign sub_in64  = (sub[pBYTECNT_SIZE-1:3] == '0);
    // Subbyte 0 is the MSB, so the byte lane is the inverted low bits.
    assign byte_idx  = ~sub[2:0];

    assign host_wr = ~usb_ncs & ~usb_nwe & usb_nrd;
    assign host_rd = ~usb_ncs & ~usb_nrd;

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [pNUM_RULES-1:0] pattern_enable;
    logic                  trig_toggle;
    logic                  trig_enable;
    logic                  status_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_enable <= '0;
            trig_toggle    <= 1'b0;
            trig_enable    <= 1'b0;
        end else if (host_wr && sub_byte0) begin
            case (reg_idx)
                REG_ENABLE: pattern_enable <= usb_din[pNUM_RULES-1:0];
                REG_TOGGLE: trig_toggle    <= usb_din[0];
                REG_TRIGEN: trig_enable    <= usb_din[0];
                default: ;
            endcase
        end
    end

    assign status_clr = host_wr & sub_byte0 & (reg_idx == REG_STATUS);

    // ------------------------------------------------------------------
    // Trace history
    // ------------------------------------------------------------------
    logic [63:0] hist;
    logic        hist_new;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist     <= '0;
            hist_new <= 1'b0;
        end else begin
            if (trace_valid)
                hist <= {hist[55:0], trace_data};
            hist_new <= trace_valid;
        end
    end

    // ------------------------------------------------------------------
    // Rule array
    // ------------------------------------------------------------------
    logic [pNUM_RULES-1:0]        pat_sel;
    logic [pNUM_RULES-1:0]        mask_sel;
    logic [pNUM_RULES-1:0][63:0]  pattern;
    logic [pNUM_RULES-1:0][63:0]  mask;
    logic [pNUM_RULES-1:0]        hit;

    for (genvar n = 0; n < pNUM_RULES; n++) begin : g_rule
        assign pat_sel[n]  = (reg_idx == REG_W'(16 + n)) & sub_in64;
        assign mask_sel[n] = (reg_idx == REG_W'(32 + n)) & sub_in64;

        cw305_trace_match_rule u_rule (
            .clk      (clk),
            .reset    (reset),
            .pat_we   (host_wr & pat_sel[n]),
            .mask_we  (host_wr & mask_sel[n]),
            .byte_idx (byte_idx),
            .wr_data  (usb_din),
            .enable   (pattern_enable[n]),
            .hist_new (hist_new),
            .hist     (hist),
            .pattern  (pattern[n]),
            .mask     (mask[n]),
            .hit      (hit[n])
        );
    end

    // ------------------------------------------------------------------
    // Flags and trigger
    // ------------------------------------------------------------------
    logic fire;

    assign fire = trig_enable & (|hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_flags <= '0;
            trig_out    <= 1'b0;
        end else begin
            // A hit on the same edge as a status clear survives the clear.
            match_flags <= (status_clr ? '0 : match_flags) | hit;
            // Pulse mode reloads every cycle, so leaving toggle mode drops
            // trig_out on the first edge without a hit.
            if (trig_toggle)
                trig_out <= trig_out ^ fire;
            else
                trig_out <= fire;
        end
    end

    // ------------------------------------------------------------------
    // Readback
    // ------------------------------------------------------------------
    logic [7:0] en_pad;
    logic [7:0] flags_pad;
    logic [7:0] rd_byte;

    always_comb begin
        en_pad                   = '0;
        en_pad[pNUM_RULES-1:0]   = pattern_enable;
    end

    always_comb begin
        flags_pad                 = '0;
        flags_pad[pNUM_RULES-1:0] = match_flags;
    end

    always_comb begin
        rd_byte = 8'h00;
        if (sub_byte0) begin
            case (reg_idx)
                REG_ENABLE: rd_byte = en_pad;
                REG_TOGGLE: rd_byte = {7'd0, trig_toggle};
                REG_TRIGEN: rd_byte = {7'd0, trig_enable};
                REG_STATUS: rd_byte = flags_pad;
                default:    rd_byte = 8'h00;
            endcase
        end
        for (int n = 0; n < pNUM_RULES; n++) begin
            if (pat_sel[n])
                rd_byte = pattern[n][{byte_idx, 3'b000} +: 8];
            if (mask_sel[n])
                rd_byte = mask[n][{byte_idx, 3'b000} +: 8];
        end
    end

    // usb_dout keeps the last read value; only the enable drops when the
    // read strobe is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            usb_dout    <= 8'h00;
            usb_dout_en <= 1'b0;
        end else if (host_rd) begin
            usb_dout    <= rd_byte;
            usb_dout_en <= 1'b1;
        end else if (usb_nrd) begin
            usb_dout_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cw305_trace_match_top.sv
module tb_cw305_trace_match_top;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [20:0] usb_addr = '0;
    logic [7:0]  usb_din = '0;
    logic [7:0]  usb_dout;
    logic        usb_dout_en;
    logic        usb_nrd = 1'b1;
    logic        usb_nwe = 1'b1;
    logic        usb_ncs = 1'b1;
    logic [7:0]  trace_data = '0;
    logic        trace_valid = 1'b0;
    logic        trig_out;
    logic [N-1:0] match_flags;

    always #5 clk = ~clk;

    cw305_trace_match_top #(
        .pADDR_WIDTH   (21),
        .pBYTECNT_SIZE (7),
        .pNUM_RULES    (N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .usb_addr    (usb_addr),
        .usb_din     (usb_din),
        .usb_dout    (usb_dout),
        .usb_dout_en (usb_dout_en),
        .usb_nrd     (usb_nrd),
        .usb_nwe     (usb_nwe),
        .usb_ncs     (usb_ncs),
        .trace_data  (trace_data),
        .trace_valid (trace_valid),
        .trig_out    (trig_out),
        .match_flags (match_flags)
    );

    typedef struct packed {
        logic         trig;
        logic [N-1:0] flags;
        logic         den;
        logic [7:0]   dout;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_en;
    logic        m_tog, m_tgen;
    logic [63:0] m_pat [N];
    logic [63:0] m_mask[N];
    logic [N-1:0] m_flags;
    logic        m_trig;
    logic [7:0]  m_dout;
    logic        m_den;
    logic [7:0]  m_hb[8];   // m_hb[k] = byte received k bytes ago (0 = newest)
    logic        m_new;

    function automatic void m_reset();
        m_en = 0; m_tog = 0; m_tgen = 0; m_flags = 0; m_trig = 0;
        m_dout = 0; m_den = 0; m_new = 0;
        for (int i = 0; i < N; i++) begin m_pat[i] = 0; m_mask[i] = 0; end
        for (int k = 0; k < 8; k++) m_hb[k] = 0;
    endfunction

    function automatic logic [7:0] m_read(int r, int s);
        if (r >= 16 && r < 16 + N && s < 8) return 8'(m_pat[r-16] >> (8 * (7 - s)));
        if (r >= 32 && r < 32 + N && s < 8) return 8'(m_mask[r-32] >> (8 * (7 - s)));
        if (s != 0) return 8'h00;
        case (r)
            0: return m_en;
            1: return {7'd0, m_tog};
            2: return {7'd0, m_tgen};
            3: return 8'(m_flags);
            default: return 8'h00;
        endcase
    endfunction

    function automatic void m_write(int r, int s, logic [7:0] d);
        int sh;
        sh = 8 * (7 - s);
        if (r >= 16 && r < 16 + N && s < 8)
            m_pat[r-16] = (m_pat[r-16] & ~(64'hFF << sh)) | (64'(d) << sh);
        else if (r >= 32 && r < 32 + N && s < 8)
            m_mask[r-32] = (m_mask[r-32] & ~(64'hFF << sh)) | (64'(d) << sh);
        else if (s == 0) begin
            case (r)
                0: m_en = d & 8'((1 << N) - 1);
                1: m_tog = d[0];
                2: m_tgen = d[0];
                default: ;
            endcase
        end
    endfunction

    // Byte-wise comparison of the last eight received bytes with each rule.
    function automatic logic [N-1:0] m_hits();
        logic [N-1:0] h;
        logic ok;
        h = 0;
        for (int r = 0; r < N; r++) begin
            if (m_new && m_en[r]) begin
                ok = 1;
                for (int k = 0; k < 8; k++)
                    if (((m_hb[k] ^ 8'(m_pat[r] >> (8 * k))) & 8'(m_mask[r] >> (8 * k))) != 0)
                        ok = 0;
                h[r] = ok;
            end
        end
        return h;
    endfunction

    // One clock cycle: drive inputs, advance the model across the coming
    // edge, queue the expected outputs, then wait for the next negedge.
    task automatic cyc(input logic rst, input logic ncs, input logic nwe, input logic nrd,
                       input int r, input int s, input logic [7:0] d,
                       input logic tv, input logic [7:0] td);
        logic [N-1:0] h;
        exp_t e;
        reset = rst; usb_ncs = ncs; usb_nwe = nwe; usb_nrd = nrd;
        usb_addr = {14'(r), 7'(s)}; usb_din = d;
        trace_valid = tv; trace_data = td;
        if (rst) m_reset();
        else begin
            h = m_hits();
            if (!ncs && !nwe && nrd && r == 3 && s == 0) m_flags = 0;
            m_flags = m_flags | h;
            if (m_tog) m_trig = m_trig ^ (m_tgen & (h != 0));
            else       m_trig = m_tgen & (h != 0);
            if (!ncs && !nrd) begin m_dout = m_read(r, s); m_den = 1; end
            else if (nrd) m_den = 0;
            if (!ncs && !nwe && nrd) m_write(r, s, d);
            if (tv) begin
                for (int k = 7; k > 0; k--) m_hb[k] = m_hb[k-1];
                m_hb[0] = td;
            end
            m_new = tv;
        end
        e.trig = m_trig; e.flags = m_flags; e.den = m_den; e.dout = m_dout;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wr(input int r, input int s, input logic [7:0] d);
        cyc(0, 0, 0, 1, r, s, d, 0, 8'h00);
    endtask
    task automatic rd(input int r, input int s);
        cyc(0, 0, 1, 0, r, s, 8'h00, 0, 8'h00);
    endtask
    task automatic tr(input logic [7:0] b);
        cyc(0, 1, 1, 1, 0, 0, 8'h00, 1, b);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 1, 1, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("trig_out", 64'(trig_out), 64'(mon_e.trig));
            chk("match_flags", 64'(match_flags), 64'(mon_e.flags));
            chk("usb_dout_en", 64'(usb_dout_en), 64'(mon_e.den));
            chk("usb_dout", 64'(usb_dout), 64'(mon_e.dout));
        end
    end

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 3))
            0: return 8'hAA;
            1: return 8'hBB;
            2: return 8'hCC;
            default: return 8'h11;
        endcase
    endfunction

    // ---------------- stimulus ----------------
    initial begin : drive
        int kind, r, s;
        logic [7:0] d;
        logic tv;

        cyc(1, 1, 1, 1, 0, 0, 8'h00, 0, 8'h00);
        cyc(1, 1, 1, 1, 0, 0, 8'h00, 1, 8'hAA);
        idle(1);

        // pattern byte writes and readback, unmapped reads
        wr(16, 4, 8'h12); wr(16, 5, 8'h34); wr(16, 6, 8'h56); wr(16, 7, 8'h78);
        for (int k = 0; k < 8; k++) rd(16, k);
        rd(48, 0); rd(16, 9); rd(24, 0); idle(1);

        // single-rule pulse
        wr(16, 6, 8'hAA); wr(16, 7, 8'hBB); wr(32, 6, 8'hFF); wr(32, 7, 8'hFF);
        wr(0, 0, 8'h01); wr(2, 0, 8'h01); wr(1, 0, 8'h00);
        tr(8'h11); tr(8'hAA); tr(8'hBB); tr(8'hCC); idle(2); rd(3, 0);

        // toggle mode, then back to pulse while high
        wr(1, 0, 8'h01);
        tr(8'hAA); tr(8'hBB); tr(8'hAA); tr(8'hBB); tr(8'hAA); tr(8'hBB); idle(2);
        wr(1, 0, 8'h00); idle(2);

        // two rules on the same byte, then status clear
        wr(19, 6, 8'hAA); wr(19, 7, 8'hBB); wr(35, 7, 8'hFF);
        wr(0, 0, 8'h09); wr(3, 0, 8'h00);
        tr(8'hAA); tr(8'hBB); idle(1); rd(3, 0); wr(3, 0, 8'h00); rd(3, 0);

        // clear on the same edge as a hit
        tr(8'hAA); tr(8'hBB); wr(3, 0, 8'h00); rd(3, 0);

        // trigger disabled, then rules disabled
        wr(3, 0, 8'h00); wr(2, 0, 8'h00);
        tr(8'hAA); tr(8'hBB); idle(1); rd(3, 0);
        wr(3, 0, 8'h00); wr(0, 0, 8'h00); wr(2, 0, 8'h01);
        tr(8'hAA); tr(8'hBB); idle(1); rd(3, 0);

        // reset between AA and BB
        wr(0, 0, 8'h01);
        tr(8'hAA);
        cyc(1, 1, 1, 1, 0, 0, 8'h00, 0, 8'h00);
        tr(8'hBB); idle(1);
        rd(0, 0); rd(1, 0); rd(2, 0); rd(3, 0); rd(16, 7); rd(32, 7);

        // zero-mask rule fires on every new byte
        wr(0, 0, 8'h04); wr(2, 0, 8'h01);
        tr(8'h42); tr(8'h43); idle(1); tr(8'h44); idle(2);

        // randomized phase
        for (int i = 0; i < 2000; i++) begin
            kind = $urandom_range(0, 9);
            tv = ($urandom_range(0, 1) == 1);
            d = pick_byte();
            r = 0; s = 0;
            if ($urandom_range(0, 399) == 0)
                cyc(1, 1, 1, 1, 0, 0, 8'h00, tv, d);
            else if (kind == 6 || kind == 7) begin
                case ($urandom_range(0, 7))
                    0: begin r = 0; d = 8'($urandom()); end
                    1: begin r = 1; d = 8'($urandom_range(0, 1)); end
                    2: begin r = 2; d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h01; end
                    3: r = ($urandom_range(0, 3) == 0) ? 3 : 24;
                    4, 5: begin r = 16 + $urandom_range(0, N - 1); s = $urandom_range(0, 8); end
                    default: begin
                        r = 32 + $urandom_range(0, N - 1); s = $urandom_range(0, 8);
                        case ($urandom_range(0, 3))
                            0: d = 8'h00; 1: d = 8'hFF; 2: d = 8'hF0; default: d = 8'h0F;
                        endcase
                    end
                endcase
                cyc(0, 0, 0, 1, r, s, d, tv, pick_byte());
            end else if (kind == 8) begin
                r = $urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 16 + $urandom_range(0, 31);
                s = $urandom_range(0, 9);
                cyc(0, 0, 1, 0, r, s, 8'h00, tv, d);
            end else if (kind == 9)
                cyc(0, 1, 0, 0, 3, 0, 8'h00, tv, d);
            else
                cyc(0, 1, 1, 1, 0, 0, 8'h00, tv, d);
        end
        idle(3);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
